// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles big-endian 16-bit words from a
// length-prefixed image, writes them to imem, then releases the core.
module imem_boot_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [15:0]       imem_wr_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] len;
  logic [15:0] len_full;
  logic        xfer;
  logic        last;

  assign xfer     = byte_valid && byte_ready;
  assign len_full = {len[15:8], byte_data};
  assign last     = (32'(words_loaded) + 32'd1) == 32'(len);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = LEN_HI;
      LEN_HI:  if (xfer) nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)
            nxt = DONE;
          else if (32'(len_full) > 32'(DEPTH))
            nxt = ERROR;
          else
            nxt = DATA_HI;
        end
      end
      DATA_HI: if (xfer) nxt = DATA_LO;
      DATA_LO: if (xfer) nxt = WRITE;
      WRITE:   nxt = last ? DONE : DATA_HI;
      DONE:    if (start) nxt = LEN_HI;
      ERROR:   nxt = ERROR;
      default: nxt = IDLE;
    endcase
  end

  // Flag outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
    end else begin
      state      <= nxt;
      byte_ready <= (nxt == LEN_HI) || (nxt == LEN_LO) ||
                    (nxt == DATA_HI) || (nxt == DATA_LO);
      busy       <= (nxt == LEN_HI) || (nxt == LEN_LO) ||
                    (nxt == DATA_HI) || (nxt == DATA_LO) ||
                    (nxt == WRITE);
      imem_wr_en <= (nxt == WRITE);
      cpu_rst    <= (nxt != DONE);
      done       <= (nxt == DONE);
      err        <= (nxt == ERROR);
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            words_loaded <= '0;
            imem_wr_addr <= '0;
          end
        end
        LEN_HI:  if (xfer) len[15:8] <= byte_data;
        LEN_LO:  if (xfer) len[7:0] <= byte_data;
        DATA_HI: if (xfer) imem_wr_data[15:8] <= byte_data;
        DATA_LO: if (xfer) imem_wr_data[7:0] <= byte_data;
        WRITE: begin
          imem_wr_addr <= imem_wr_addr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued by
// the stimulus, and a negedge monitor pops them on each write strobe.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_wr_en;
  logic [15:0] imem_wr_addr;
  logic [15:0] imem_wr_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];
  logic prev_en = 1'b0;

  imem_boot_loader #(.DEPTH(256), .ADDR_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && imem_wr_en) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {imem_wr_addr, imem_wr_data}, 32'hdead);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("wr_addr", 32'(imem_wr_addr), 32'(e[31:16]));
        check("wr_data", 32'(imem_wr_data), 32'(e[15:0]));
      end
      check("ready_on_strobe", 32'(byte_ready), 0);
      check("strobe_width", 32'(prev_en), 0);
    end
    prev_en = rst ? 1'b0 : imem_wr_en;
  end

  task automatic send(input logic [7:0] b, input bit rnd);
    int guard = 0;
    bit sent = 0;
    while (!sent) begin
      @(negedge clk);
      if (rnd && ($urandom_range(0, 2) == 0)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        if (byte_ready) sent = 1;
      end
      guard++;
      if (guard > 1000 && !sent) begin
        check("send_timeout", 0, 1);
        sent = 1;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 1);
  endtask

  task automatic push3();
    sb.push_back({16'd0, 16'h1234});
    sb.push_back({16'd1, 16'hABCD});
    sb.push_back({16'd2, 16'h00FF});
  endtask

  task automatic send3(input bit rnd);
    logic [7:0] img [8];
    img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    for (int i = 0; i < 8; i++) send(img[i], rnd);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_words", 32'(words_loaded), 0);
    check("rst_addr", 32'(imem_wr_addr), 0);
    check("rst_data", 32'(imem_wr_data), 0);
    rst = 1'b0;

    // nominal load with byte_valid held high
    push3();
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    send3(0);
    @(negedge clk);
    byte_valid = 1'b0;
    check("last_strobe", 32'(imem_wr_en), 1);
    check("cpu_rst_during", 32'(cpu_rst), 1);
    @(negedge clk);
    check("nom_done", 32'(done), 1);
    check("nom_cpu_rst", 32'(cpu_rst), 0);
    check("nom_words", 32'(words_loaded), 3);
    check("nom_addr", 32'(imem_wr_addr), 3);
    check("nom_data_held", 32'(imem_wr_data), 32'h00FF);
    check("nom_sb_empty", 32'(sb.size()), 0);

    // reload from DONE with random gaps; start while busy is ignored
    push3();
    pulse_start();
    check("reload_cpu_rst", 32'(cpu_rst), 1);
    check("reload_done", 32'(done), 0);
    send(8'h00, 1);
    send(8'h03, 1);
    send(8'h12, 1);
    pulse_start();
    check("start_busy_ign", 32'(busy), 1);
    send(8'h34, 1);
    send(8'hAB, 1);
    send(8'hCD, 1);
    send(8'h00, 1);
    send(8'hFF, 1);
    @(negedge clk);
    byte_valid = 1'b0;
    wait_done();
    check("bp_words", 32'(words_loaded), 3);
    check("bp_sb_empty", 32'(sb.size()), 0);

    // zero length
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_cpu_rst", 32'(cpu_rst), 0);
    check("zero_words", 32'(words_loaded), 0);

    // abort after one word
    sb.push_back({16'd0, 16'h1234});
    pulse_start();
    send(8'h00, 0);
    send(8'h03, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    check("abort_strobe", 32'(imem_wr_en), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_cpu_rst", 32'(cpu_rst), 1);
    check("async_ready", 32'(byte_ready), 0);
    check("async_busy", 32'(busy), 0);
    check("async_words", 32'(words_loaded), 0);
    check("async_addr", 32'(imem_wr_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back({16'd0, 16'h5678});
    sb.push_back({16'd1, 16'h9ABC});
    pulse_start();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h56, 0);
    send(8'h78, 0);
    send(8'h9A, 0);
    send(8'hBC, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    wait_done();
    check("reload_words", 32'(words_loaded), 2);
    check("reload_sb_empty", 32'(sb.size()), 0);

    // full-depth image: N == DEPTH
    for (int i = 0; i < 256; i++)
      sb.push_back({16'(i), 8'(i), ~8'(i)});
    pulse_start();
    send(8'h01, 0);
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 0);
      send(~8'(i), 0);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    wait_done();
    check("full_words", 32'(words_loaded), 256);
    check("full_addr", 32'(imem_wr_addr), 256);
    check("full_sb_empty", 32'(sb.size()), 0);

    // overflow: N = 257
    pulse_start();
    send(8'h01, 0);
    send(8'h01, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    check("ovf_err", 32'(err), 1);
    check("ovf_cpu_rst", 32'(cpu_rst), 1);
    check("ovf_ready", 32'(byte_ready), 0);
    check("ovf_done", 32'(done), 0);
    pulse_start();
    @(negedge clk);
    check("ovf_start_ign", 32'(err), 1);
    check("ovf_not_busy", 32'(busy), 0);
    #2 rst = 1'b1;
    #1;
    check("ovf_rst_clear", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream boot loader sitting directly upstream of the 16-bit multicycle processor top.
- Receives a length-prefixed program image over a valid/ready byte interface and assembles big-endian 16-bit instruction words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the processor core in reset until the full image is loaded, then releases it.

Parameters:
- DEPTH, 256, instruction memory capacity in 16-bit words; maximum legal image length.
- ADDR_W, 16, width of the write address, matching the 16-bit PC.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- byte_valid  input  1  upstream byte is present.
- byte_data  input  8  upstream byte.
- byte_ready  output  1  loader accepts byte_data this cycle.
- imem_wr_en  output  1  one-cycle instruction-memory write strobe.
- imem_wr_addr  output  ADDR_W  word address for the write.
- imem_wr_data  output  16  assembled instruction word.
- cpu_rst  output  1  reset to the processor core; high while loading.
- busy  output  1  high in any load state (LEN_HI through WRITE).
- done  output  1  image loaded, core running.
- err  output  1  image length exceeded DEPTH.
- words_loaded  output  ADDR_W  count of words written in the current load.

Behaviour:
- Reset (async, rst=1): state=IDLE, cpu_rst=1, byte_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, busy=0, done=0, err=0, words_loaded=0, internal length register=0.
- Reset mid-load aborts immediately to IDLE. Partially written memory contents are left as-is.
- A byte transfer occurs only on a clock edge where byte_valid && byte_ready. byte_data is don't-care otherwise.
- All outputs are registered.
- Image format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words, each sent as high byte then low byte.
- States and transitions:
  - IDLE: byte_ready=0, cpu_rst=1. On start: clear words_loaded, clear imem_wr_addr, clear done and err, go to LEN_HI.
  - LEN_HI: byte_ready=1. On transfer: latch len[15:8], go to LEN_LO.
  - LEN_LO: byte_ready=1. On transfer: latch len[7:0], then branch on the full N:
    - N==0 → DONE.
    - N>DEPTH → ERROR.
    - otherwise → DATA_HI.
  - DATA_HI: byte_ready=1. On transfer: latch imem_wr_data[15:8], go to DATA_LO.
  - DATA_LO: byte_ready=1. On transfer: latch imem_wr_data[7:0], go to WRITE.
  - WRITE: byte_ready=0, imem_wr_en=1 for exactly this one cycle with the current imem_wr_addr. On exit: imem_wr_addr+=1, words_loaded+=1. If words_loaded+1==N → DONE, else → DATA_HI.
  - DONE: cpu_rst=0, done=1, byte_ready=0. On start: cpu_rst=1 and done=0 on the next cycle, behave as from IDLE.
  - ERROR: err=1, cpu_rst=1, byte_ready=0. Leaves only via rst; start is ignored.
- Timing and throughput:
  - imem_wr_en asserts on the cycle after the DATA_LO transfer.
  - Peak throughput is 2 bytes per 3 cycles.
  - cpu_rst deasserts on the cycle after the final WRITE cycle.
- Boundary conditions:
  - start while busy is ignored.
  - byte_valid while byte_ready=0 is not consumed; the upstream must hold the byte.
  - N==DEPTH is legal. The last address written is DEPTH-1 and imem_wr_addr ends at DEPTH.
  - Addresses never wrap, because N is bounded by DEPTH.
  - imem_wr_data is held stable outside WRITE.
- busy = state in {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE}.

Test Plan:
- Reset check: assert rst asynchronously between clock edges → all outputs at reset values immediately; cpu_rst=1 and byte_ready=0 with no clock edge required.
- Nominal load: start, then bytes 00 03 12 34 AB CD 00 FF, byte_valid held high → three write strobes:
  - addr0=0x1234, addr1=0xABCD, addr2=0x00FF.
  - Each strobe is 1 cycle wide and byte_ready=0 on strobe cycles.
  - done=1, cpu_rst=0 and words_loaded=3 one cycle after the last strobe.
- Backpressure and gaps: same image with byte_valid toggled randomly and byte_data changed while byte_valid=0 → identical writes; no extra or dropped bytes.
- Zero length: bytes 00 00 → no imem_wr_en ever; DONE on the cycle after LEN_LO; cpu_rst=0.
- Overflow: with DEPTH=256, send bytes 01 01 (N=257) → ERROR, err=1, cpu_rst=1, byte_ready=0. start is ignored; only rst clears err.
- Abort and reload:
  - Assert rst after 1 of 3 words is written → IDLE with cpu_rst=1.
  - A fresh start plus a 2-word image → writes begin at addr 0.
  - start from DONE reasserts cpu_rst on the next cycle and reloads.
